// File: rtl/cache_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : cache_line_responder
//  Purpose  : Memory-side responder for the cache bus line-transfer
//             interface. Fetches stream a line out of a small backing store
//             into FetchBuffer one beat per cycle. Writebacks sample one
//             beat of WriteBeatData per cycle, with the word chosen by
//             BeatCount.
//
//  Ports    : clk           - clock
//             reset         - asynchronous, active-low reset
//             CacheBusRW    - [1] line fetch, [0] line writeback; 2'b11 is
//                             treated as a writeback
//             CacheBusAdr   - line-aligned bus address (offset bits ignored)
//             WriteBeatData - writeback beat from the cache (word BeatCount)
//             BeatCount     - current beat index
//             SelBusBeat    - high during writeback beats
//             FetchBuffer   - assembled fetched line
//             CacheBusAck   - one-cycle pulse on the final beat
//             BusErr        - error qualifier, valid with CacheBusAck
//             Busy          - transaction in progress (WAIT/READ/WRITE)
//
//  Options  : CACHE_RESP_ERR_EN - when defined, a nonzero address bit above
//             the line index makes the access out of range. It still runs
//             every beat, but reads return zero, writes are dropped and
//             BusErr is raised with the Ack. When undefined, the upper bits
//             are ignored and the index wraps modulo MEMLINES.
//
//  Revision : 1.0 - initial release
// ============================================================================
module cache_line_responder #(
    parameter int PA_BITS  = 32,
    parameter int LINELEN  = 512,
    parameter int BEATLEN  = 64,
    parameter int LOGBWPL  = 3,
    parameter int MEMLINES = 256,
    parameter int LATENCY  = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [1:0]         CacheBusRW,
    input  logic [PA_BITS-1:0] CacheBusAdr,
    input  logic [BEATLEN-1:0] WriteBeatData,
    output logic [LOGBWPL-1:0] BeatCount,
    output logic               SelBusBeat,
    output logic [LINELEN-1:0] FetchBuffer,
    output logic               CacheBusAck,
    output logic               BusErr,
    output logic               Busy
);

    localparam int c_OFFSET_BITS = $clog2(LINELEN / 8);
    localparam int c_IDX_BITS    = $clog2(MEMLINES);
    localparam int c_IDX_LO      = c_OFFSET_BITS;
    localparam int c_IDX_HI      = c_OFFSET_BITS + c_IDX_BITS - 1;
    localparam int c_BEATS       = 2 ** LOGBWPL;
    localparam int c_MEM_WORDS   = MEMLINES * c_BEATS;

    localparam logic [LOGBWPL-1:0] c_LAST_BEAT = '1;
    // WAIT lasts exactly LATENCY cycles, so the counter is preloaded with
    // LATENCY-1 and the beat state is entered when it reads zero.
    localparam logic [3:0] c_LAT_LOAD = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_WAIT  = 3'd1,
        S_READ  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                   r_state;
    state_t                   w_stateNext;
    logic [LOGBWPL-1:0]       r_beatCount;
    logic [LOGBWPL-1:0]       w_beatNext;
    logic [3:0]               r_latCnt;
    logic [3:0]               w_latNext;
    logic [c_IDX_BITS-1:0]    r_lineIdx;
    logic                     r_dirWrite;
    logic                     r_outOfRange;
    logic [LINELEN-1:0]       r_fetchBuffer;

    logic                     w_accept;
    logic                     w_readBeat;
    logic                     w_writeBeat;
    logic                     w_ack;
    logic                     w_abort;
    logic                     w_outOfRange;
    logic                     w_unusedAdrBits;

    logic [BEATLEN-1:0]       r_mem [c_MEM_WORDS];
    logic [c_IDX_BITS+LOGBWPL-1:0] w_memAddr;
    logic [BEATLEN-1:0]       w_memRdData;

`ifdef CACHE_RESP_ERR_EN
    assign w_outOfRange    = |CacheBusAdr[PA_BITS-1:c_IDX_HI+1];
    assign w_unusedAdrBits = ^CacheBusAdr[c_IDX_LO-1:0];
    assign BusErr          = w_ack & r_outOfRange;
`else
    assign w_outOfRange    = 1'b0;
    assign w_unusedAdrBits = ^{CacheBusAdr[PA_BITS-1:c_IDX_HI+1], CacheBusAdr[c_IDX_LO-1:0]};
    assign BusErr          = 1'b0;
`endif

    // Dropping the request to 2'b00 while busy abandons the transaction.
    assign w_abort = (CacheBusRW == 2'b00);

    // ------------------------------------------------------------------
    // Next-state and strobe logic
    // ------------------------------------------------------------------
    always_comb begin
        w_stateNext = r_state;
        w_beatNext  = r_beatCount;
        w_latNext   = r_latCnt;
        w_accept    = 1'b0;
        w_readBeat  = 1'b0;
        w_writeBeat = 1'b0;
        w_ack       = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (CacheBusRW != 2'b00) begin
                    w_accept   = 1'b1;
                    w_beatNext = '0;
                    if (LATENCY == 0) begin
                        w_stateNext = CacheBusRW[0] ? S_WRITE : S_READ;
                    end else begin
                        w_stateNext = S_WAIT;
                        w_latNext   = c_LAT_LOAD;
                    end
                end
            end

            S_WAIT: begin
                if (w_abort) begin
                    w_stateNext = S_IDLE;
                    w_beatNext  = '0;
                end else if (r_latCnt == 4'd0) begin
                    w_stateNext = r_dirWrite ? S_WRITE : S_READ;
                end else begin
                    w_latNext = r_latCnt - 4'd1;
                end
            end

            S_READ, S_WRITE: begin
                if (w_abort) begin
                    w_stateNext = S_IDLE;
                    w_beatNext  = '0;
                end else begin
                    w_readBeat  = (r_state == S_READ);
                    w_writeBeat = (r_state == S_WRITE);
                    // Natural wrap returns BeatCount to 0 after the last beat.
                    w_beatNext  = r_beatCount + 1'b1;
                    if (r_beatCount == c_LAST_BEAT) begin
                        w_ack       = 1'b1;
                        w_stateNext = S_DONE;
                    end
                end
            end

            // One dead cycle so a request still held after Ack is not
            // mistaken for a new one.
            S_DONE: begin
                w_stateNext = S_IDLE;
            end

            default: begin
                w_stateNext = S_IDLE;
                w_beatNext  = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_beatCount   <= '0;
            r_latCnt      <= 4'd0;
            r_lineIdx     <= '0;
            r_dirWrite    <= 1'b0;
            r_outOfRange  <= 1'b0;
            r_fetchBuffer <= '0;
        end else begin
            r_state     <= w_stateNext;
            r_beatCount <= w_beatNext;
            r_latCnt    <= w_latNext;
            if (w_accept) begin
                r_lineIdx    <= CacheBusAdr[c_IDX_HI:c_IDX_LO];
                r_dirWrite   <= CacheBusRW[0];
                r_outOfRange <= w_outOfRange;
            end
            if (w_readBeat) begin
                r_fetchBuffer[int'(r_beatCount) * BEATLEN +: BEATLEN] <=
                    r_outOfRange ? '0 : w_memRdData;
            end
        end
    end

    // ------------------------------------------------------------------
    // Backing store: one word per beat, addressed {line, beat}. Not reset.
    // ------------------------------------------------------------------
    assign w_memAddr   = {r_lineIdx, r_beatCount};
    assign w_memRdData = r_mem[w_memAddr];

    always_ff @(posedge clk) begin
        if (w_writeBeat && !r_outOfRange) begin
            r_mem[w_memAddr] <= WriteBeatData;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign BeatCount   = r_beatCount;
    assign SelBusBeat  = (r_state == S_WRITE);
    assign FetchBuffer = r_fetchBuffer;
    assign CacheBusAck = w_ack;
    assign Busy        = (r_state == S_WAIT) || (r_state == S_READ) || (r_state == S_WRITE);

endmodule
`default_nettype wire

// File: tb/tb_cache_line_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_line_responder
//  Purpose  : Self-checking bench for cache_line_responder. A behavioural
//             model (line array plus expected fetch buffer) predicts every
//             cycle of each transaction: WAIT length, beat indices, select,
//             Ack/BusErr timing and the assembled line.
//  Ports    : none
//  Options  : CACHE_RESP_ERR_EN selects the out-of-range expectations.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cache_line_responder;

    localparam int LAT = 2;
    localparam int NBEATS = 8;

    logic         clk;
    logic         reset;
    logic [1:0]   CacheBusRW;
    logic [31:0]  CacheBusAdr;
    logic [63:0]  WriteBeatData;
    logic [2:0]   BeatCount;
    logic         SelBusBeat;
    logic [511:0] FetchBuffer;
    logic         CacheBusAck;
    logic         BusErr;
    logic         Busy;

    int nCompared;
    int nMismatched;

    // Reference model
    logic [63:0]  mdlMem [256][NBEATS];
    logic [511:0] expFb;
    logic [63:0]  wbuf [NBEATS];

    cache_line_responder #(
        .PA_BITS (32),
        .LINELEN (512),
        .BEATLEN (64),
        .LOGBWPL (3),
        .MEMLINES(256),
        .LATENCY (LAT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .CacheBusRW   (CacheBusRW),
        .CacheBusAdr  (CacheBusAdr),
        .WriteBeatData(WriteBeatData),
        .BeatCount    (BeatCount),
        .SelBusBeat   (SelBusBeat),
        .FetchBuffer  (FetchBuffer),
        .CacheBusAck  (CacheBusAck),
        .BusErr       (BusErr),
        .Busy         (Busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic checkVal(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        nCompared++;
        if (obs !== exp) begin
            nMismatched++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit isOor(input logic [31:0] a);
`ifdef CACHE_RESP_ERR_EN
        return |a[31:14];
`else
        return 1'b0;
`endif
    endfunction

    // Runs one transaction from IDLE. abortBeat >= 0 drops the request in
    // that beat cycle, so beats below it complete and the rest never happen.
    task automatic runTxn(input logic [1:0] rw, input logic [31:0] adr, input int abortBeat);
        bit isWr;
        bit oor;
        int line;
        int k;
        isWr = rw[0];
        oor  = isOor(adr);
        line = int'(adr[13:6]);
        CacheBusRW    = rw;
        CacheBusAdr   = adr;
        WriteBeatData = '0;
        @(negedge clk);
        checkVal("idleBusy", Busy, 1'b0);
        @(posedge clk);                      // accept edge
        for (int c = 1; c <= LAT + NBEATS; c++) begin
            k = c - LAT - 1;
            #1;
            if (k >= 0) WriteBeatData = wbuf[k];
            if (k >= 0 && k == abortBeat) CacheBusRW = 2'b00;
            @(negedge clk);
            checkVal("busy", Busy, 1'b1);
            checkVal("beat", BeatCount, (k >= 0) ? k : 0);
            checkVal("sel", SelBusBeat, (k >= 0) && isWr);
            checkVal("ack", CacheBusAck, (k == NBEATS - 1) && (abortBeat != k));
            checkVal("err", BusErr, (k == NBEATS - 1) && (abortBeat != k) && oor);
            @(posedge clk);
            if (k >= 0 && k == abortBeat) begin
                #1;
                checkVal("abortBusy", Busy, 1'b0);
                checkVal("abortBeat", BeatCount, 0);
                checkVal("abortFb", FetchBuffer, expFb);
                return;
            end
            if (k >= 0) begin
                if (isWr) begin
                    if (!oor) mdlMem[line][k] = wbuf[k];
                end else begin
                    expFb[k*64 +: 64] = oor ? 64'd0 : mdlMem[line][k];
                end
            end
        end
        // DONE cycle with the request still held
        @(negedge clk);
        checkVal("doneBusy", Busy, 1'b0);
        checkVal("doneAck", CacheBusAck, 1'b0);
        checkVal("doneBeat", BeatCount, 0);
        checkVal("fetchBuf", FetchBuffer, expFb);
        @(posedge clk);
        #1;
        CacheBusRW = 2'b00;
    endtask

    task automatic fillBuf(input logic [63:0] base, input bit rnd);
        for (int i = 0; i < NBEATS; i++)
            wbuf[i] = rnd ? {$urandom, $urandom} : base + 64'(i);
    endtask

    initial begin
        logic [1:0]  rw;
        logic [31:0] adr;
        int ab;

        nCompared     = 0;
        nMismatched   = 0;
        expFb         = '0;
        reset         = 1'b0;
        CacheBusRW    = 2'b00;
        CacheBusAdr   = '0;
        WriteBeatData = '0;

        // Reset values
        repeat (2) @(posedge clk);
        #2;
        checkVal("rstBusy", Busy, 1'b0);
        checkVal("rstBeat", BeatCount, 0);
        checkVal("rstSel", SelBusBeat, 1'b0);
        checkVal("rstAck", CacheBusAck, 1'b0);
        checkVal("rstErr", BusErr, 1'b0);
        checkVal("rstFb", FetchBuffer, 512'd0);
        reset = 1'b1;

        // Preload lines 0..15; line 5 gets 0x10+k
        for (int l = 0; l < 16; l++) begin
            if (l == 5) fillBuf(64'h10, 1'b0);
            else        fillBuf(64'h0, 1'b1);
            runTxn(2'b01, 32'(l * 64), -1);
        end

        // Fetch line 5 with a nonzero offset
        runTxn(2'b10, 32'(5 * 64 + 8), -1);

        // Writeback line 7 then back-to-back fetch
        fillBuf(64'hA0, 1'b0);
        runTxn(2'b01, 32'(7 * 64), -1);
        runTxn(2'b10, 32'(7 * 64), -1);

        // Abort writeback after beat 3, then fetch: beats 0..3 new, 4..7 old
        fillBuf(64'hB0, 1'b0);
        runTxn(2'b01, 32'(7 * 64), 4);
        runTxn(2'b10, 32'(7 * 64), -1);

        // 2'b11 treated as writeback
        fillBuf(64'hC0, 1'b0);
        runTxn(2'b11, 32'(9 * 64), -1);
        runTxn(2'b10, 32'(9 * 64), -1);

        // Out-of-range address (line 0 when the error check is disabled)
        runTxn(2'b10, 32'(256 * 64), -1);
        fillBuf(64'hD0, 1'b0);
        runTxn(2'b01, 32'(256 * 64 + 3 * 64), -1);
        runTxn(2'b10, 32'(3 * 64), -1);

        // Async reset mid-READ at beat 3
        CacheBusRW  = 2'b10;
        CacheBusAdr = 32'(5 * 64);
        @(posedge clk);
        repeat (LAT + 3) @(posedge clk);
        #2;
        checkVal("preRstBeat", BeatCount, 3);
        reset = 1'b0;
        #1;
        checkVal("midRstBusy", Busy, 1'b0);
        checkVal("midRstBeat", BeatCount, 0);
        checkVal("midRstAck", CacheBusAck, 1'b0);
        checkVal("midRstFb", FetchBuffer, 512'd0);
        expFb      = '0;
        CacheBusRW = 2'b00;
        @(posedge clk);
        #2;
        reset = 1'b1;
        @(posedge clk);
        #1;
        runTxn(2'b10, 32'(5 * 64), -1);

        // Randomized traffic over the preloaded lines
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 2))
                0:       rw = 2'b10;
                1:       rw = 2'b01;
                default: rw = 2'b11;
            endcase
            adr = {18'd0, 8'($urandom_range(0, 15)), 6'($urandom_range(0, 63))};
            if ($urandom_range(0, 7) == 0) adr[31:14] = 18'($urandom_range(1, 262143));
            ab = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 7)) : -1;
            fillBuf(64'h0, 1'b1);
            runTxn(rw, adr, ab);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule
`default_nettype wire
